// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter and sequencer for a shared 4-input
// selection path. One requester at a time holds the grant for a bounded
// burst. The 2-bit select steers that requester's operand into a single
// registered output stage. The output stage supports back-pressure.
module mux_rr_arbiter #(
    parameter int W        = 4,
    parameter int MAXBURST = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req,
    input  logic [3:0]   last,
    input  logic [W-1:0] i0,
    input  logic [W-1:0] i1,
    input  logic [W-1:0] i2,
    input  logic [W-1:0] i3,
    input  logic         y_ready,
    output logic [3:0]   gnt,
    output logic [1:0]   s,
    output logic [3:0]   ack,
    output logic [W-1:0] y,
    output logic         y_valid
);

    localparam int CW = $clog2(MAXBURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t         state, state_nxt;
    logic [1:0]     ptr, ptr_nxt;
    logic [3:0]     gnt_nxt;
    logic [1:0]     s_nxt;
    logic [CW-1:0]  cnt, cnt_nxt, cnt_inc;
    logic [W-1:0]   y_nxt;
    logic           y_valid_nxt;

    logic           free;
    logic           take;
    logic           burst_done;
    logic           grant_end;
    logic [7:0]     req_dbl;
    logic [3:0]     req_rot;
    logic [1:0]     pick_ofs;
    logic [1:0]     pick;
    logic [W-1:0]   sel_data;

    // Output register can accept a beat when empty or being drained this cycle.
    assign free = ~y_valid | y_ready;

    // A beat moves only while granted, with the owner requesting and room downstream.
    assign take       = (state == GRANT) & req[s] & free;
    assign cnt_inc    = cnt + 1'b1;
    assign burst_done = (cnt_inc == CW'(MAXBURST));
    assign grant_end  = (state == GRANT) & ((take & (last[s] | burst_done)) | ~req[s]);
    assign ack        = take ? (4'b0001 << s) : 4'b0000;

    // Rotate requests so bit 0 is the requester at ptr; the lowest set bit wins.
    assign req_dbl = {req, req} >> ptr;
    assign req_rot = req_dbl[3:0];

    // Priority pick of the first requester at or after ptr in rotated order.
    always_comb begin
        pick_ofs = 2'd3;
        if (req_rot[0]) begin
            pick_ofs = 2'd0;
        end else if (req_rot[1]) begin
            pick_ofs = 2'd1;
        end else if (req_rot[2]) begin
            pick_ofs = 2'd2;
        end
    end

    assign pick = ptr + pick_ofs;

    // Operand steering for the granted requester.
    always_comb begin
        sel_data = i0;
        case (s)
            2'd0:    sel_data = i0;
            2'd1:    sel_data = i1;
            2'd2:    sel_data = i2;
            default: sel_data = i3;
        endcase
    end

    // Next-state logic for the FSM, the grant/select, the burst counter and the output stage.
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        gnt_nxt     = gnt;
        s_nxt       = s;
        cnt_nxt     = cnt;
        y_nxt       = y;
        y_valid_nxt = y_valid;

        // The output stage empties when drained, but a beat taken in the same cycle refills it.
        if (take) begin
            y_nxt       = sel_data;
            y_valid_nxt = 1'b1;
        end else if (y_ready) begin
            y_valid_nxt = 1'b0;
        end

        case (state)
            IDLE: begin
                if (|req) begin
                    gnt_nxt   = 4'b0001 << pick;
                    s_nxt     = pick;
                    cnt_nxt   = '0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (take) begin
                    cnt_nxt = cnt_inc;
                end
                // Last beat, full burst or withdrawal all end the grant once; s is kept.
                if (grant_end) begin
                    state_nxt = IDLE;
                    ptr_nxt   = s + 2'd1;
                    gnt_nxt   = 4'b0000;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 4'b0000;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= 2'd0;
            gnt     <= 4'b0000;
            s       <= 2'd0;
            cnt     <= '0;
            y       <= '0;
            y_valid <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            gnt     <= gnt_nxt;
            s       <= s_nxt;
            cnt     <= cnt_nxt;
            y       <= y_nxt;
            y_valid <= y_valid_nxt;
        end
    end

endmodule
